// File: rtl/b09_pkg.sv
//------------------------------------------------------------------------------
// Module   : b09_pkg
// Brief    : Shared types, line levels and round-robin pick for b09 TX scheduler
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package b09_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic FRAME_START_BIT = 1'b1;
    localparam logic IDLE_LEVEL      = 1'b0;
    localparam int   MAX_REQ         = 8;
    localparam int   PICK_IDX_W      = 3;

    // Returns {found, index}: first set bit of valid at or above ptr, wrapping at n.
    function automatic logic [PICK_IDX_W:0] rr_pick(
        input logic [MAX_REQ-1:0]    valid,
        input logic [PICK_IDX_W-1:0] ptr,
        input int unsigned           n
    );
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
        int unsigned           cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= n) cand = cand - n;
            if ((i < n) && !found && valid[cand[PICK_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[PICK_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter, one-hot grant plus index
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import b09_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any_grant
);

    localparam int ID_W = $clog2(N_REQ);

    logic [MAX_REQ-1:0]    w_valid_pad;
    logic [PICK_IDX_W-1:0] w_ptr_pad;
    logic [PICK_IDX_W:0]   w_pick;

    always_comb begin
        w_valid_pad              = '0;
        w_valid_pad[N_REQ-1:0]   = req_valid;
        w_ptr_pad                = '0;
        w_ptr_pad[ID_W-1:0]      = rr_ptr;
    end

    assign w_pick    = rr_pick(w_valid_pad, w_ptr_pad, N_REQ);
    assign any_grant = w_pick[PICK_IDX_W];
    assign grant_idx = w_pick[ID_W-1:0];

    for (genvar i = 0; i < N_REQ; i++) begin : g_grant
        assign grant[i] = w_pick[PICK_IDX_W] && (w_pick[PICK_IDX_W-1:0] == PICK_IDX_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/b09_tx_scheduler.sv
//------------------------------------------------------------------------------
// Module   : b09_tx_scheduler
// Brief    : Round-robin framer sharing one serial line among N_REQ producers
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module b09_tx_scheduler
    import b09_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tx_en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      ser_out,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      frame_done
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any;
    logic               w_accept;
    logic [DATA_W-1:0]  w_sel_word;

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_grant (w_any)
    );

    assign w_accept  = (r_state == IDLE) && tx_en && w_any && !reset;
    assign req_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_sel_word = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            ser_out    <= IDLE_LEVEL;
            busy       <= 1'b0;
            grant_id   <= '0;
            frame_done <= 1'b0;
            r_rr_ptr   <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= w_sel_word;
                        grant_id <= w_grant_idx;
                        r_rr_ptr <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
                        ser_out  <= FRAME_START_BIT;
                        busy     <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    ser_out   <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= DATA;
                end
                DATA: begin
                    // The last data bit has been on the line for a cycle; open the gap.
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        ser_out    <= IDLE_LEVEL;
                        frame_done <= 1'b1;
                        r_gap_cnt  <= '0;
                        r_state    <= GAP;
                    end else begin
                        ser_out   <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    ser_out <= IDLE_LEVEL;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/b09_tx_scheduler.md
Name: b09_tx_scheduler

Overview:
Round-robin scheduler that shares one b09-style serial output line among N_REQ word producers. Each cycle in IDLE it grants one requester, captures that requester's word and sequences it onto ser_out as a framed bitstream: start bit, DATA_W data bits, then an idle gap. It sits upstream of the serial converter's X input and is the only driver of that line.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, word width per requester
GAP_CYC, 2, idle '0' cycles after each frame (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
tx_en  in  1  gates acceptance of new frames only
req_valid  in  N_REQ  per-requester word available
req_data  in  N_REQ*DATA_W  packed words, requester i at bits [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot accept strobe (combinational)
ser_out  out  1  serial line (registered)
busy  out  1  high in any state other than IDLE (registered)
grant_id  out  clog2(N_REQ)  index of requester whose frame is in flight (registered)
frame_done  out  1  one-cycle pulse in the first GAP cycle (registered)

Behaviour:
- Clocking: one clock, all state updated on the rising edge of clock; reset is synchronous, active-high.
- Reset values: state=IDLE, ser_out=0, busy=0, grant_id=0, frame_done=0, rr_ptr=0, shift reg=0, counters=0. req_ready is 0 while reset=1.
- FSM states: IDLE, START, DATA, GAP.
- IDLE: if tx_en=1 and any req_valid, choose the first valid index searching upward from rr_ptr with wrap. req_ready[g]=1 in that same cycle. At the edge: capture req_data[g] into the shift reg, grant_id<=g, rr_ptr<=(g+1) mod N_REQ, state<=START. Otherwise stay in IDLE with req_ready=0.
- Handshake: transfer occurs on the edge where req_valid[i]&req_ready[i]. Requester i holds its valid and data stable until that edge. req_ready is never asserted outside IDLE.
- START: ser_out=1 for one cycle, then DATA with bit counter=0.
- DATA: ser_out = shift reg bit 0 (LSB first), shift right each cycle, DATA_W cycles, then GAP.
- GAP: ser_out=0 for GAP_CYC cycles. frame_done=1 only in the first GAP cycle. Then IDLE.
- Latency: for an accept at edge E0, the start bit appears on ser_out after E0. Data bits appear after edges E1..E8, and GAP after E9. Back-to-back frame period = 2+DATA_W+GAP_CYC cycles (12 at defaults), because acceptance happens in the single IDLE cycle.
- busy=1 in START, DATA and GAP. grant_id holds its value until the next grant.
- tx_en falling mid-frame: the current frame completes unchanged. tx_en blocks only the next IDLE acceptance.
- req_valid dropping mid-frame: no effect, because the data is already captured.
- Fairness: a requester that stays valid is granted within N_REQ frames. A lone requester is granted every frame.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset mid-frame: at the reset edge, ser_out=0 and state=IDLE. The frame is aborted with no frame_done, and the captured word is discarded (not re-requested).
- Idle line level is 0. No output X/undefined values at any time.

Decomposition:
- Shared package b09_pkg:
  - state enum (IDLE, START, DATA, GAP)
  - FRAME_START_BIT=1'b1, IDLE_LEVEL=1'b0
  - function for the round-robin priority pick
- One natural sub-module, rr_arbiter: inputs req_valid, rr_ptr; outputs one-hot grant and index; purely combinational. The FSM, shifter and counters stay in b09_tx_scheduler.

Test Plan:
1. Reset, then req_valid[0]=1, data=8'hA5, tx_en=1 -> req_ready=4'b0001 for 1 cycle; ser_out = 1,1,0,1,0,0,1,0,1,0,0; frame_done pulses in cycle 10 after accept.
2. All four valid continuously, data 8'h01/02/03/04 -> grant order 0,1,2,3,0; frames spaced exactly 12 cycles; grant_id follows.
3. Only req 2 valid after req 1 was granted -> grant 2. Then req 0 and req 3 both valid -> req 3 wins (rr_ptr=3), then req 0 wins.
4. tx_en=0 with req_valid=4'b1111 -> req_ready stays 0 and ser_out stays 0. Drop tx_en mid-DATA -> frame finishes, and no new accept follows.
5. Reset asserted in the 4th DATA cycle -> ser_out=0, busy=0 the next cycle, no frame_done, rr_ptr=0 (next grant goes to req 0).
6. req_valid[1] deasserted during its frame, with data changed to 8'hFF -> the serialized bits still match the originally captured 8'h3C.
